// File: rtl/wb_multi_retire_pkg.sv
// Shared constants and types for the multi-lane write-back stage and its trace FIFO.
package wb_multi_retire_pkg;

    localparam int unsigned PC_W         = 32;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned STALL_MEM_WB = 4;
    localparam int unsigned STALL_WB     = 5;
    localparam logic        STOP         = 1'b1;
    localparam logic        NO_STOP      = 1'b0;

    typedef enum logic [1:0] {
        WB_HOLD    = 2'd0,
        WB_CAPTURE = 2'd1,
        WB_BUBBLE  = 2'd2
    } wb_action_e;

    // Width of one MEM->WB lane: {pc, we, waddr, wdata}
    function automatic int unsigned wb_lane_w(input int unsigned addr_w, input int unsigned data_w);
        return PC_W + 1 + addr_w + data_w;
    endfunction

    // Width of one WB->RF lane: {we, waddr, wdata}
    function automatic int unsigned wb_rf_lane_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/wb_multi_retire_trace_fifo.sv
// Multi-push (up to LANES per cycle, in lane order), single-pop circular trace buffer.
module wb_trace_fifo
    import wb_multi_retire_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 70
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [LANES-1:0]              push_valid_i,
    input  logic [LANES*W-1:0]            push_data_i,
    output logic [W-1:0]                  head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] push_cnt;
    logic [PTR_W-1:0] slot [LANES];
    logic             pop;
    logic             overflow;

    // Valid lanes are compacted into consecutive slots starting at the write pointer.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wr_ptr_q + PTR_W'(push_cnt);
            if (push_valid_i[i]) begin
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
        pop      = (count_q != '0);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + push_cnt - CNT_W'(pop);
        overflow = (SUM_W'(count_q) + SUM_W'(push_cnt)) > SUM_W'(DEPTH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_valid_i[i]) begin
                mem_q[slot[i]] <= push_data_i[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (!overflow);
        end
    end

    assign head_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/wb_multi_retire.sv
// Multi-lane write-back stage: pipeline register, same-address conflict masking, RF/forwarding
// lane packing, and a trace FIFO serialising retired lanes onto the debug port.
module wb_multi_retire
    import wb_multi_retire_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned TRACE_DEPTH = 4
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [STALL_W-1:0]                     stall,
    input  logic                                   flush,
    input  logic [LANES*(PC_W+1+ADDR_W+DATA_W)-1:0] mem_to_wb_bus,
    input  logic [LANES-1:0]                       mem_valid,
    output logic [LANES*(1+ADDR_W+DATA_W)-1:0]     wb_to_rf_bus,
    output logic [LANES-1:0]                       wb_we_o,
    output logic [LANES*ADDR_W-1:0]                wb_waddr_o,
    output logic [LANES*DATA_W-1:0]                wb_wdata_o,
    output logic                                   stallreq_wb,
    output logic [PC_W-1:0]                        debug_wb_pc,
    output logic [3:0]                             debug_wb_rf_wen,
    output logic [ADDR_W-1:0]                      debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                      debug_wb_rf_wdata
);

    localparam int unsigned LW    = wb_lane_w(ADDR_W, DATA_W);
    localparam int unsigned RW    = wb_rf_lane_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W = $clog2(TRACE_DEPTH + 1);

    wb_action_e           action;
    logic [LANES*RW-1:0]  rf_q, rf_d;
    logic [LANES-1:0]     valid_q, valid_d;
    logic [LANES-1:0]     lane_we, rf_we;
    logic [LANES-1:0]     push_valid;
    logic [LANES*LW-1:0]  push_data;
    logic [LW-1:0]        head;
    logic [CNT_W-1:0]     count;
    logic                 unused_stall;

    assign unused_stall = ^stall[STALL_MEM_WB-1:0];

    always_comb begin
        action = WB_HOLD;
        if (flush) begin
            action = WB_BUBBLE;
        end else if (stall[STALL_MEM_WB] == STOP && stall[STALL_WB] == NO_STOP) begin
            action = WB_BUBBLE;
        end else if (stall[STALL_MEM_WB] == NO_STOP) begin
            action = WB_CAPTURE;
        end
    end

    // Only {we,waddr,wdata} is kept in WB; the PC goes straight to the trace FIFO.
    always_comb begin
        rf_d    = rf_q;
        valid_d = valid_q;
        case (action)
            WB_BUBBLE: begin
                rf_d    = '0;
                valid_d = '0;
            end
            WB_CAPTURE: begin
                valid_d = mem_valid;
                for (int i = 0; i < LANES; i++) begin
                    rf_d[i*RW +: RW] = mem_to_wb_bus[i*LW +: RW];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_q    <= '0;
            valid_q <= '0;
        end else begin
            rf_q    <= rf_d;
            valid_q <= valid_d;
        end
    end

    // r0 writes are dropped; an older lane loses to any younger lane writing the same register.
    always_comb begin
        lane_we = '0;
        rf_we   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = valid_q[i] & rf_q[i*RW + ADDR_W + DATA_W]
                         & (rf_q[i*RW + DATA_W +: ADDR_W] != '0);
        end
        for (int i = 0; i < LANES; i++) begin
            rf_we[i] = lane_we[i];
            for (int j = i + 1; j < int'(LANES); j++) begin
                if (lane_we[j] && (rf_q[j*RW + DATA_W +: ADDR_W] == rf_q[i*RW + DATA_W +: ADDR_W])) begin
                    rf_we[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            wb_to_rf_bus[i*RW +: RW]       = {rf_we[i], rf_q[i*RW +: ADDR_W + DATA_W]};
            wb_we_o[i]                     = rf_we[i];
            wb_waddr_o[i*ADDR_W +: ADDR_W] = rf_q[i*RW + DATA_W +: ADDR_W];
            wb_wdata_o[i*DATA_W +: DATA_W] = rf_q[i*RW +: DATA_W];
        end
    end

    // Trace entries mirror the incoming lane but carry the r0-masked write enable.
    always_comb begin
        push_valid = (action == WB_CAPTURE) ? mem_valid : '0;
        for (int i = 0; i < LANES; i++) begin
            push_data[i*LW +: LW] = {mem_to_wb_bus[i*LW + RW +: PC_W],
                                     mem_to_wb_bus[i*LW + ADDR_W + DATA_W]
                                     & (mem_to_wb_bus[i*LW + DATA_W +: ADDR_W] != '0),
                                     mem_to_wb_bus[i*LW +: ADDR_W + DATA_W]};
        end
    end

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (TRACE_DEPTH),
        .W     (LW)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .head_data_o  (head),
        .count_o      (count)
    );

    assign stallreq_wb       = (CNT_W'(TRACE_DEPTH) - count) < CNT_W'(LANES);
    assign debug_wb_pc       = head[LW-1 -: PC_W];
    assign debug_wb_rf_wen   = {4{head[ADDR_W + DATA_W]}};
    assign debug_wb_rf_wnum  = head[DATA_W +: ADDR_W];
    assign debug_wb_rf_wdata = head[DATA_W-1:0];

endmodule

// File: tb/tb_wb_multi_retire.sv
// Directed bench for wb_multi_retire with default parameters (2 lanes, 4-entry trace FIFO).
module tb_wb_multi_retire;

    logic         clk = 1'b0;
    logic         resetn;
    logic [5:0]   stall;
    logic         flush;
    logic [139:0] mem_to_wb_bus;
    logic [1:0]   mem_valid;
    logic [75:0]  wb_to_rf_bus;
    logic [1:0]   wb_we_o;
    logic [9:0]   wb_waddr_o;
    logic [63:0]  wb_wdata_o;
    logic         stallreq_wb;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int checks = 0;
    int errors = 0;

    wb_multi_retire dut (
        .clk               (clk),
        .resetn            (resetn),
        .stall             (stall),
        .flush             (flush),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_valid         (mem_valid),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_we_o           (wb_we_o),
        .wb_waddr_o        (wb_waddr_o),
        .wb_wdata_o        (wb_wdata_o),
        .stallreq_wb       (stallreq_wb),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] mk(input logic [31:0] pc, input logic we,
                                       input logic [4:0] a, input logic [31:0] d);
        return {pc, we, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        mem_valid = 2'b00;
        stall     = 6'b0;
        flush     = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++;
        if (wb_to_rf_bus !== 76'd0 || wb_we_o !== 2'b00) begin
            errors++; $display("FAIL reset_rf: got we=%b bus=%h, expected 0", wb_we_o, wb_to_rf_bus);
        end
        checks++;
        if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0 || stallreq_wb !== 1'b0) begin
            errors++; $display("FAIL reset_dbg: got pc=%h wen=%h stallreq=%b, expected 0", debug_wb_pc, debug_wb_rf_wen, stallreq_wb);
        end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_dual_write();
        logic [37:0] exp_l0;
        idle(3);
        exp_l0 = {1'b1, 5'd3, 32'h11};
        mem_to_wb_bus = {mk(32'h104, 1'b1, 5'd4, 32'h22), mk(32'h100, 1'b1, 5'd3, 32'h11)};
        mem_valid = 2'b11;
        step();
        mem_valid = 2'b00;
        checks++;
        if (wb_we_o !== 2'b11) begin errors++; $display("FAIL dual_we: got %b expected 11", wb_we_o); end
        checks++;
        if (wb_to_rf_bus[37:0] !== exp_l0 || wb_wdata_o !== 64'h00000022_00000011 || wb_waddr_o !== {5'd4, 5'd3}) begin
            errors++; $display("FAIL dual_rf: got bus=%h data=%h addr=%h", wb_to_rf_bus, wb_wdata_o, wb_waddr_o);
        end
        checks++;
        if (debug_wb_pc !== 32'h100 || debug_wb_rf_wnum !== 5'd3 || debug_wb_rf_wdata !== 32'h11 || debug_wb_rf_wen !== 4'hf) begin
            errors++; $display("FAIL dual_trace0: got %h/%0d/%h/%h expected 100/3/11/f", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_rf_wen);
        end
        checks++;
        if (stallreq_wb !== 1'b0) begin errors++; $display("FAIL dual_stallreq: got %b expected 0", stallreq_wb); end
        step();
        checks++;
        if (debug_wb_pc !== 32'h104 || debug_wb_rf_wnum !== 5'd4 || debug_wb_rf_wdata !== 32'h22 || debug_wb_rf_wen !== 4'hf) begin
            errors++; $display("FAIL dual_trace1: got %h/%0d/%h expected 104/4/22", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
        end
        checks++;
        if (wb_we_o !== 2'b00) begin errors++; $display("FAIL dual_bubble: got %b expected 00", wb_we_o); end
        step();
        checks++;
        if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0) begin
            errors++; $display("FAIL dual_empty: got pc=%h wen=%h expected 0", debug_wb_pc, debug_wb_rf_wen);
        end
    endtask

    task automatic test_conflict();
        logic [37:0] exp_l1;
        idle(2);
        exp_l1 = {1'b1, 5'd5, 32'hBB};
        mem_to_wb_bus = {mk(32'h204, 1'b1, 5'd5, 32'hBB), mk(32'h200, 1'b1, 5'd5, 32'hAA)};
        mem_valid = 2'b11;
        step();
        mem_valid = 2'b00;
        checks++;
        if (wb_we_o !== 2'b10) begin errors++; $display("FAIL conflict_we: got %b expected 10", wb_we_o); end
        checks++;
        if (wb_to_rf_bus[75:38] !== exp_l1 || wb_to_rf_bus[37] !== 1'b0) begin
            errors++; $display("FAIL conflict_rf: got %h", wb_to_rf_bus);
        end
        checks++;
        if (debug_wb_pc !== 32'h200 || debug_wb_rf_wdata !== 32'hAA || debug_wb_rf_wen !== 4'hf) begin
            errors++; $display("FAIL conflict_trace0: got %h/%h/%h expected 200/aa/f", debug_wb_pc, debug_wb_rf_wdata, debug_wb_rf_wen);
        end
        step();
        checks++;
        if (debug_wb_pc !== 32'h204 || debug_wb_rf_wdata !== 32'hBB || debug_wb_rf_wen !== 4'hf) begin
            errors++; $display("FAIL conflict_trace1: got %h/%h/%h expected 204/bb/f", debug_wb_pc, debug_wb_rf_wdata, debug_wb_rf_wen);
        end
    endtask

    task automatic test_r0_stall();
        idle(3);
        mem_to_wb_bus = {mk(32'h0, 1'b0, 5'd0, 32'h0), mk(32'h300, 1'b1, 5'd0, 32'h55)};
        mem_valid = 2'b01;
        step();
        checks++;
        if (wb_we_o !== 2'b00 || wb_to_rf_bus[37] !== 1'b0) begin
            errors++; $display("FAIL r0_rf: got we=%b expected 00", wb_we_o);
        end
        checks++;
        if (debug_wb_pc !== 32'h300 || debug_wb_rf_wen !== 4'h0 || debug_wb_rf_wdata !== 32'h55) begin
            errors++; $display("FAIL r0_trace: got %h/%h/%h expected 300/0/55", debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wdata);
        end
        mem_to_wb_bus = {mk(32'h0, 1'b0, 5'd0, 32'h0), mk(32'h310, 1'b1, 5'd6, 32'h66)};
        step();
        mem_to_wb_bus = {mk(32'h0, 1'b0, 5'd0, 32'h0), mk(32'h320, 1'b1, 5'd7, 32'h77)};
        stall = 6'b010000;
        step();
        checks++;
        if (wb_we_o !== 2'b00 || debug_wb_pc !== 32'd0) begin
            errors++; $display("FAIL stall_bubble: got we=%b pc=%h expected 00/0", wb_we_o, debug_wb_pc);
        end
        stall = 6'b0;
        mem_to_wb_bus = {mk(32'h0, 1'b0, 5'd0, 32'h0), mk(32'h310, 1'b1, 5'd6, 32'h66)};
        step();
        mem_to_wb_bus = {mk(32'h0, 1'b0, 5'd0, 32'h0), mk(32'h320, 1'b1, 5'd7, 32'h77)};
        stall = 6'b110000;
        step();
        checks++;
        if (wb_we_o !== 2'b01 || wb_waddr_o[4:0] !== 5'd6 || wb_wdata_o[31:0] !== 32'h66 || debug_wb_pc !== 32'd0) begin
            errors++; $display("FAIL stall_hold: got we=%b a=%0d d=%h pc=%h expected 01/6/66/0", wb_we_o, wb_waddr_o[4:0], wb_wdata_o[31:0], debug_wb_pc);
        end
        step();
        checks++;
        if (wb_we_o !== 2'b01 || wb_wdata_o[31:0] !== 32'h66 || debug_wb_pc !== 32'd0) begin
            errors++; $display("FAIL stall_hold2: got we=%b d=%h pc=%h expected 01/66/0", wb_we_o, wb_wdata_o[31:0], debug_wb_pc);
        end
        idle(1);
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_pc [6];
        int sent = 0;
        int got  = 0;
        idle(3);
        for (int k = 0; k < 6; k++) exp_pc[k] = 32'h400 + 32'(4 * k);
        for (int c = 0; c < 20; c++) begin
            if (debug_wb_pc !== 32'd0) begin
                if (got < 6) begin
                    checks++;
                    if (debug_wb_pc !== exp_pc[got] || debug_wb_rf_wnum !== 5'(8 + got)) begin
                        errors++; $display("FAIL bp_order%0d: got %h/%0d expected %h/%0d", got, debug_wb_pc, debug_wb_rf_wnum, exp_pc[got], 8 + got);
                    end
                end
                got++;
            end
            if (c == 1) begin
                checks++;
                if (stallreq_wb !== 1'b0) begin errors++; $display("FAIL bp_stallreq_c2: got %b expected 0", stallreq_wb); end
            end
            if (c == 2) begin
                checks++;
                if (stallreq_wb !== 1'b1) begin errors++; $display("FAIL bp_stallreq_c3: got %b expected 1", stallreq_wb); end
            end
            if (stallreq_wb === 1'b1) begin
                stall = 6'b110000;
            end else begin
                stall = 6'b0;
                if (sent < 3) begin
                    mem_to_wb_bus = {mk(exp_pc[2*sent+1], 1'b1, 5'(9 + 2*sent), 32'(32'h81 + 2*sent)),
                                     mk(exp_pc[2*sent],   1'b1, 5'(8 + 2*sent), 32'(32'h80 + 2*sent))};
                    mem_valid = 2'b11;
                    sent++;
                end else begin
                    mem_valid = 2'b00;
                end
            end
            step();
        end
        checks++;
        if (got != 6) begin errors++; $display("FAIL bp_total: got %0d entries expected 6", got); end
        idle(1);
    endtask

    task automatic test_flush();
        idle(3);
        mem_to_wb_bus = {mk(32'h504, 1'b1, 5'd15, 32'hE1), mk(32'h500, 1'b1, 5'd14, 32'hE0)};
        mem_valid = 2'b11;
        step();
        mem_to_wb_bus = {mk(32'h604, 1'b1, 5'd17, 32'hF1), mk(32'h600, 1'b1, 5'd16, 32'hF0)};
        flush = 1'b1;
        step();
        flush = 1'b0;
        mem_valid = 2'b00;
        checks++;
        if (wb_we_o !== 2'b00) begin errors++; $display("FAIL flush_bubble: got %b expected 00", wb_we_o); end
        checks++;
        if (debug_wb_pc !== 32'h504) begin errors++; $display("FAIL flush_drain: got %h expected 504", debug_wb_pc); end
        step();
        checks++;
        if (debug_wb_pc !== 32'd0) begin errors++; $display("FAIL flush_nopush: got %h expected 0", debug_wb_pc); end
    endtask

    task automatic test_reset_mid();
        idle(3);
        mem_to_wb_bus = {mk(32'h704, 1'b1, 5'd19, 32'h71), mk(32'h700, 1'b1, 5'd18, 32'h70)};
        mem_valid = 2'b11;
        step();
        mem_to_wb_bus = {mk(32'h70c, 1'b1, 5'd21, 32'h73), mk(32'h708, 1'b1, 5'd20, 32'h72)};
        step();
        mem_valid = 2'b00;
        stall = 6'b110000;
        checks++;
        if (stallreq_wb !== 1'b1 || wb_we_o !== 2'b11) begin
            errors++; $display("FAIL rstmid_pre: got stallreq=%b we=%b expected 1/11", stallreq_wb, wb_we_o);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (wb_we_o !== 2'b00 || wb_to_rf_bus !== 76'd0 || stallreq_wb !== 1'b0) begin
            errors++; $display("FAIL rstmid_rf: got we=%b bus=%h stallreq=%b expected 0", wb_we_o, wb_to_rf_bus, stallreq_wb);
        end
        checks++;
        if (debug_wb_pc !== 32'd0 || debug_wb_rf_wen !== 4'd0 || debug_wb_rf_wdata !== 32'd0) begin
            errors++; $display("FAIL rstmid_dbg: got pc=%h wen=%h expected 0", debug_wb_pc, debug_wb_rf_wen);
        end
        step();
        resetn = 1'b1;
        stall = 6'b0;
        step();
        checks++;
        if (debug_wb_pc !== 32'd0 || wb_we_o !== 2'b00) begin
            errors++; $display("FAIL rstmid_after: got pc=%h we=%b expected 0", debug_wb_pc, wb_we_o);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        stall         = 6'b0;
        flush         = 1'b0;
        mem_valid     = 2'b00;
        mem_to_wb_bus = '0;
        test_reset();
        test_dual_write();
        test_conflict();
        test_r0_stall();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
